// File: rtl/board_move_arbiter_pkg.sv
// Shared chess package: arbiter state encoding, default geometry and move-word flag positions.
package board_move_arbiter_pkg;

  localparam int NCOL_DEF = 8;
  localparam int MW_DEF   = 160;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_GEN  = 3'd2,
    ST_SEL  = 3'd3,
    ST_RD   = 3'd4,
    ST_CAP  = 3'd5,
    ST_OUT  = 3'd6,
    ST_FIN  = 3'd7
  } arb_state_t;

  // Flag bits occupy the low end of every move word.
  localparam int MV_F_INVALID = 0;
  localparam int MV_F_PROMOTE = 1;
  localparam int MV_F_PAWN    = 2;
  localparam int MV_F_PAWN2   = 3;
  localparam int MV_F_EP      = 4;
  localparam int MV_F_CASTLE  = 5;
  localparam int MV_F_CAPTURE = 6;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/board_move_arbiter_rr.sv
// Round-robin finder: first set request at or after start, wrapping at N.
module rr_first_set #(
  parameter int N  = 8,
  parameter int PW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] start,
  output logic [PW-1:0] idx,
  output logic          found
);

  logic [2*N-1:0] rot;
  logic [PW-1:0]  off;
  logic [PW:0]    sum;

  // Doubling the vector turns the wrap-around scan into a plain low-bit search.
  assign rot = {req, req} >> start;

  always_comb begin
    off   = '0;
    found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off   = PW'(k);
        found = 1'b1;
      end
    end
    sum = {1'b0, start} + {1'b0, off};
    if (sum >= (PW + 1)'(N)) sum = sum - (PW + 1)'(N);
    idx = sum[PW-1:0];
  end

endmodule

// File: rtl/board_move_arbiter.sv
// Collects move words from the column FIFOs into a single ready/valid output register.
// state | meaning
// IDLE  | waiting for start        CLR | pulse col_reset, clear count/ptr
// GEN   | wait for all col_done    SEL | pick next non-empty column from ptr
// RD    | col_rden[ptr]            CAP | register col_q[ptr]
// OUT   | hold word until ready    FIN | pass_done pulse
module board_move_arbiter
  import board_move_arbiter_pkg::*;
#(
  parameter int NCOL = NCOL_DEF,
  parameter int MW   = MW_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               col_reset,
  input  logic [NCOL-1:0]    col_done,
  input  logic [NCOL-1:0]    col_empty,
  output logic [NCOL-1:0]    col_rden,
  input  logic [NCOL*MW-1:0] col_q,
  output logic [MW-1:0]      mv_data,
  output logic               mv_valid,
  input  logic               mv_ready,
  output logic               busy,
  output logic               pass_done,
  output logic [7:0]         mv_count
);

  localparam int PW = (NCOL > 1) ? $clog2(NCOL) : 1;

  arb_state_t    state, state_nxt;
  logic [PW-1:0] ptr;
  logic [PW-1:0] pick;
  logic          found;
  logic [NCOL-1:0] avail;

  assign avail = ~col_empty;

  rr_first_set #(.N(NCOL), .PW(PW)) u_rr (
    .req   (avail),
    .start (ptr),
    .idx   (pick),
    .found (found)
  );

  always_comb begin
    state_nxt = state;
    col_rden  = '0;
    col_reset = 1'b0;
    pass_done = 1'b0;
    busy      = (state != ST_IDLE);
    unique case (state)
      ST_IDLE: if (start) state_nxt = ST_CLR;
      ST_CLR: begin
        col_reset = 1'b1;
        state_nxt = ST_GEN;
      end
      ST_GEN:  if (&col_done) state_nxt = ST_SEL;
      ST_SEL:  state_nxt = found ? ST_RD : ST_FIN;
      ST_RD: begin
        col_rden[ptr] = 1'b1;
        state_nxt     = ST_CAP;
      end
      ST_CAP:  state_nxt = ST_OUT;
      ST_OUT:  if (mv_ready) state_nxt = ST_SEL;
      ST_FIN: begin
        pass_done = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      mv_data  <= '0;
      mv_valid <= 1'b0;
      mv_count <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_CLR: begin
          mv_count <= '0;
          ptr      <= '0;
        end
        ST_SEL: if (found) ptr <= pick;
        // Non-show-ahead FIFOs: q is valid the cycle after the read strobe.
        ST_CAP: begin
          mv_data  <= col_q[int'(ptr)*MW +: MW];
          mv_valid <= 1'b1;
        end
        ST_OUT: if (mv_ready) begin
          mv_valid <= 1'b0;
          mv_count <= sat_inc8(mv_count);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_board_move_arbiter.sv
// Bench for board_move_arbiter: queue-based column FIFO model, scoreboard of delivered words.
module tb_board_move_arbiter;

  localparam int NCOL = 8;
  localparam int MW   = 160;
  typedef logic [MW-1:0] word_t;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic               col_reset;
  logic [NCOL-1:0]    col_done  = '0;
  logic [NCOL-1:0]    col_empty = '1;
  logic [NCOL-1:0]    col_rden;
  logic [NCOL*MW-1:0] col_q;
  logic [MW-1:0]      mv_data;
  logic               mv_valid;
  logic               mv_ready;
  logic               busy;
  logic               pass_done;
  logic [7:0]         mv_count;

  always #5 clk = ~clk;

  board_move_arbiter #(.NCOL(NCOL), .MW(MW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .col_reset (col_reset),
    .col_done  (col_done),
    .col_empty (col_empty),
    .col_rden  (col_rden),
    .col_q     (col_q),
    .mv_data   (mv_data),
    .mv_valid  (mv_valid),
    .mv_ready  (mv_ready),
    .busy      (busy),
    .pass_done (pass_done),
    .mv_count  (mv_count)
  );

  int total = 0;
  int bad   = 0;
  int rdy_mode = 0;  // 0: always ready, 1: random ready, 2: driven by the test
  int gen_delay = 2;
  int gen_cnt = 0;

  word_t plan[NCOL][$];
  word_t fifo[NCOL][$];
  word_t q_reg[NCOL];
  word_t got[$];
  word_t exp_w[$];
  int    rd_log[$];
  int    exp_i[$];
  int    creset_cnt, pdone_cnt, rden_evt, onehot_viol, hold_viol, rden_while_valid, underflow;
  logic [7:0] cnt_at_done;
  bit    prev_hold;
  word_t prev_data;

  for (genvar g = 0; g < NCOL; g++) begin : g_q
    assign col_q[g*MW +: MW] = q_reg[g];
  end

  // Column units: col_reset wipes them, generation finishes gen_delay cycles later.
  always @(posedge clk) begin
    if (col_reset) begin
      for (int i = 0; i < NCOL; i++) fifo[i].delete();
      col_done <= '0;
      gen_cnt = gen_delay;
    end else if (gen_cnt > 0) begin
      gen_cnt--;
      if (gen_cnt == 0) begin
        for (int i = 0; i < NCOL; i++) fifo[i] = plan[i];
        col_done <= '1;
      end
    end
    for (int i = 0; i < NCOL; i++) begin
      if (col_rden[i]) begin
        if (fifo[i].size() > 0) q_reg[i] <= fifo[i].pop_front();
        else underflow++;
      end
    end
    for (int i = 0; i < NCOL; i++) col_empty[i] <= (fifo[i].size() == 0);
  end

  always @(negedge clk) begin
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (col_rden != '0) begin
        rden_evt++;
        if (!$onehot(col_rden)) onehot_viol++;
        for (int i = 0; i < NCOL; i++) if (col_rden[i]) rd_log.push_back(i);
        if (mv_valid) rden_while_valid++;
      end
      if (col_reset) creset_cnt++;
      if (pass_done) begin
        pdone_cnt++;
        cnt_at_done = mv_count;
      end
      if (prev_hold && (!mv_valid || mv_data !== prev_data)) hold_viol++;
      if (mv_valid && mv_ready) got.push_back(mv_data);
      prev_hold = mv_valid && !mv_ready;
      prev_data = mv_data;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) mv_ready = 1'b1;
      else if (rdy_mode == 1) mv_ready = ($urandom_range(0, 2) != 0);
    end
  end

  function automatic word_t rand_word();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic clear_plan();
    for (int i = 0; i < NCOL; i++) plan[i].delete();
  endtask

  task automatic rand_plan(input int maxn);
    clear_plan();
    for (int i = 0; i < NCOL; i++) begin
      int n = $urandom_range(0, maxn);
      for (int j = 0; j < n; j++) plan[i].push_back(rand_word());
    end
  endtask

  // Reference model: every column is drained completely, lowest index first.
  task automatic build_expect();
    exp_w.delete();
    exp_i.delete();
    for (int i = 0; i < NCOL; i++)
      foreach (plan[i][j]) begin
        exp_w.push_back(plan[i][j]);
        exp_i.push_back(i);
      end
  endtask

  function automatic int exp_count();
    return (exp_w.size() > 255) ? 255 : exp_w.size();
  endfunction

  function automatic int seq_diff();
    if (got.size() != exp_w.size()) return got.size();
    foreach (got[k]) if (got[k] !== exp_w[k]) return k;
    return -1;
  endfunction

  function automatic int idx_diff();
    if (rd_log.size() != exp_i.size()) return rd_log.size();
    foreach (rd_log[k]) if (rd_log[k] != exp_i[k]) return k;
    return -1;
  endfunction

  task automatic clear_logs();
    got.delete();
    rd_log.delete();
    creset_cnt = 0; pdone_cnt = 0; rden_evt = 0; onehot_viol = 0;
    hold_viol = 0; rden_while_valid = 0; underflow = 0; cnt_at_done = 8'h00;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, output bit ok);
    int n = 0;
    while (pdone_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = (pdone_cnt >= target);
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    int n = 0;
    @(negedge clk);
    while (!mv_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = mv_valid;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mv_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
    total++; if (mv_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", mv_valid); end
    total++; if (mv_data !== '0) begin bad++; $display("FAIL reset_data got %h want 0", mv_data); end
    total++; if (mv_count !== 8'd0) begin bad++; $display("FAIL reset_count got %0d want 0", mv_count); end
    total++; if (col_rden !== '0 || col_reset !== 1'b0 || pass_done !== 1'b0) begin
      bad++; $display("FAIL reset_strobes got rden=%h creset=%b done=%b want 0", col_rden, col_reset, pass_done);
    end
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_empty_pass();
    bit ok;
    clear_plan(); build_expect(); clear_logs(); rdy_mode = 0;
    pulse_start();
    wait_done(1, 100, ok);
    total++; if (!ok) begin bad++; $display("FAIL empty_timeout got done=%0d want 1", pdone_cnt); end
    total++; if (creset_cnt != 1) begin bad++; $display("FAIL empty_creset got %0d want 1", creset_cnt); end
    total++; if (cnt_at_done !== 8'd0) begin bad++; $display("FAIL empty_count got %0d want 0", cnt_at_done); end
    total++; if (rden_evt != 0) begin bad++; $display("FAIL empty_rden got %0d want 0", rden_evt); end
    @(negedge clk);
    total++; if (busy !== 1'b0 || pdone_cnt != 1) begin
      bad++; $display("FAIL empty_idle got busy=%b done=%0d want 0/1", busy, pdone_cnt);
    end
  endtask

  task automatic test_directed();
    bit ok;
    clear_plan();
    plan[2].push_back(word_t'(160'hA));
    plan[2].push_back(word_t'(160'hB));
    plan[2].push_back(word_t'(160'hC));
    plan[5].push_back(word_t'(160'hD));
    build_expect(); clear_logs(); rdy_mode = 0;
    pulse_start();
    wait_done(1, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL dir_timeout got done=%0d want 1", pdone_cnt); end
    total++; if (seq_diff() != -1) begin bad++; $display("FAIL dir_words got n=%0d want n=%0d at %0d", got.size(), exp_w.size(), seq_diff()); end
    total++; if (idx_diff() != -1 || onehot_viol != 0) begin
      bad++; $display("FAIL dir_rden got n=%0d onehot_err=%0d want n=4 onehot_err=0", rd_log.size(), onehot_viol);
    end
    total++; if (cnt_at_done !== 8'd4) begin bad++; $display("FAIL dir_count got %0d want 4", cnt_at_done); end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_plan();
    plan[4].push_back(rand_word());
    plan[4].push_back(rand_word());
    build_expect(); clear_logs(); rdy_mode = 2; mv_ready = 1'b0;
    pulse_start();
    wait_valid(100, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_valid_timeout got %b want 1", mv_valid); end
    repeat (10) begin
      @(negedge clk);
      total++; if (mv_valid !== 1'b1 || mv_data !== exp_w[0]) begin
        bad++; $display("FAIL bp_hold got v=%b d=%h want v=1 d=%h", mv_valid, mv_data, exp_w[0]);
      end
    end
    total++; if (rden_evt != 1) begin bad++; $display("FAIL bp_rden_stall got %0d want 1", rden_evt); end
    @(posedge clk); #1 mv_ready = 1'b1;
    @(posedge clk); #1 mv_ready = 1'b0;
    repeat (6) @(negedge clk);
    total++; if (got.size() != 1 || got[0] !== exp_w[0]) begin
      bad++; $display("FAIL bp_one_xfer got n=%0d want n=1", got.size());
    end
    total++; if (mv_valid !== 1'b1 || mv_data !== exp_w[1] || rden_evt != 2) begin
      bad++; $display("FAIL bp_next got v=%b rden=%0d d=%h want v=1 rden=2 d=%h", mv_valid, rden_evt, mv_data, exp_w[1]);
    end
    rdy_mode = 0;
    wait_done(1, 100, ok);
    total++; if (!ok || seq_diff() != -1 || hold_viol != 0 || rden_while_valid != 0) begin
      bad++; $display("FAIL bp_finish got done=%0d n=%0d hold_err=%0d rden_err=%0d want 1/2/0/0",
                      pdone_cnt, got.size(), hold_viol, rden_while_valid);
    end
  endtask

  task automatic test_reset_mid_pass();
    bit ok;
    clear_plan();
    for (int j = 0; j < 3; j++) plan[3].push_back(rand_word());
    build_expect(); clear_logs(); rdy_mode = 2; mv_ready = 1'b0;
    pulse_start();
    wait_valid(100, ok);
    @(posedge clk); #1 mv_ready = 1'b1;
    @(posedge clk); #1 mv_ready = 1'b0;
    wait_valid(100, ok);
    total++; if (!ok || mv_count !== 8'd1 || mv_data !== exp_w[1]) begin
      bad++; $display("FAIL rst_pre got v=%b cnt=%0d want v=1 cnt=1", mv_valid, mv_count);
    end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    total++; if (mv_valid !== 1'b0 || busy !== 1'b0 || mv_count !== 8'd0 || col_rden !== '0) begin
      bad++; $display("FAIL rst_mid got v=%b busy=%b cnt=%0d rden=%h want 0", mv_valid, busy, mv_count, col_rden);
    end
    total++; if (pdone_cnt != 0) begin bad++; $display("FAIL rst_no_done got %0d want 0", pdone_cnt); end
    rand_plan(4); build_expect(); clear_logs(); rdy_mode = 1;
    pulse_start();
    wait_done(1, 1000, ok);
    total++; if (!ok || seq_diff() != -1 || idx_diff() != -1 || cnt_at_done != 8'(exp_count())) begin
      bad++; $display("FAIL rst_clean_pass got n=%0d cnt=%0d want n=%0d cnt=%0d", got.size(), cnt_at_done, exp_w.size(), exp_count());
    end
  endtask

  task automatic test_start_while_busy();
    bit ok;
    int n = 0;
    rand_plan(3);
    plan[$urandom_range(0, NCOL - 1)].push_back(rand_word());
    build_expect(); clear_logs(); rdy_mode = 1;
    pulse_start();
    pulse_start();
    while (got.size() < 1 && n < 200) begin @(negedge clk); n++; end
    pulse_start();
    wait_done(1, 1000, ok);
    repeat (10) @(negedge clk);
    total++; if (!ok || creset_cnt != 1 || pdone_cnt != 1) begin
      bad++; $display("FAIL busy_start got creset=%0d done=%0d want 1/1", creset_cnt, pdone_cnt);
    end
    total++; if (seq_diff() != -1 || busy !== 1'b0) begin
      bad++; $display("FAIL busy_words got n=%0d busy=%b want n=%0d busy=0", got.size(), busy, exp_w.size());
    end
  endtask

  task automatic test_random();
    bit ok;
    for (int p = 0; p < 6; p++) begin
      rand_plan(5); build_expect(); clear_logs(); rdy_mode = 1;
      pulse_start();
      wait_done(1, 2000, ok);
      total++; if (!ok) begin bad++; $display("FAIL rnd_timeout pass=%0d got done=%0d want 1", p, pdone_cnt); end
      total++; if (seq_diff() != -1) begin
        bad++; $display("FAIL rnd_words pass=%0d got n=%0d want n=%0d at %0d", p, got.size(), exp_w.size(), seq_diff());
      end
      total++; if (idx_diff() != -1 || onehot_viol != 0 || underflow != 0) begin
        bad++; $display("FAIL rnd_rden pass=%0d got n=%0d uf=%0d want n=%0d uf=0", p, rd_log.size(), underflow, exp_i.size());
      end
      total++; if (cnt_at_done != 8'(exp_count()) || hold_viol != 0) begin
        bad++; $display("FAIL rnd_count pass=%0d got cnt=%0d hold_err=%0d want cnt=%0d", p, cnt_at_done, hold_viol, exp_count());
      end
    end
  endtask

  task automatic test_saturate();
    bit ok;
    clear_plan();
    for (int j = 0; j < 300; j++) plan[0].push_back(rand_word());
    build_expect(); clear_logs(); rdy_mode = 0;
    pulse_start();
    wait_done(1, 3000, ok);
    total++; if (!ok) begin bad++; $display("FAIL sat_timeout got done=%0d want 1", pdone_cnt); end
    total++; if (seq_diff() != -1) begin bad++; $display("FAIL sat_words got n=%0d want 300", got.size()); end
    total++; if (cnt_at_done !== 8'd255) begin bad++; $display("FAIL sat_count got %0d want 255", cnt_at_done); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mv_ready = 1'b0;
    clear_logs(); prev_hold = 1'b0;
    test_reset();
    test_empty_pass();
    test_directed();
    test_backpressure();
    test_reset_mid_pass();
    test_start_while_busy();
    test_random();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
